// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a full payload from the upstream source, then sends
// header, payload and XOR parity to the router, stalling on busy.
module router_pkt_tx #(
    parameter int MAX_LEN = 63
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] tx_addr,
    input  logic [5:0] tx_len,
    output logic       cmd_ready,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FILL    = 3'd1;
    localparam logic [2:0] ST_HEADER  = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_PARITY  = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [5:0] MAX_LEN_C = 6'(MAX_LEN);

    function automatic logic [7:0] parity_step(input logic [7:0] acc, input logic [7:0] b);
        parity_step = acc ^ b;
    endfunction

    logic [2:0] state_r;
    logic [1:0] addr_r;
    logic [5:0] len_r;
    logic [5:0] wr_ptr_r;
    logic [5:0] rd_ptr_r;
    logic [7:0] parity_r;
    logic       pkt_valid_r;
    logic [7:0] data_out_r;
    logic       done_r;
    logic       err_r;
    logic       cmd_ready_r;
    logic       pl_ready_r;
    logic [7:0] buf_mem [0:63];

    logic [7:0] header_s;
    logic       xfer_s;
    logic       req_legal_s;

    assign header_s    = {len_r, addr_r};
    assign xfer_s      = pl_valid & pl_ready_r;
    assign req_legal_s = (tx_addr != 2'd3) && (tx_len != 6'd0) && (tx_len <= MAX_LEN_C);

    assign cmd_ready = cmd_ready_r;
    assign pl_ready  = pl_ready_r;
    assign pkt_valid = pkt_valid_r;
    assign data_out  = data_out_r;
    assign done      = done_r;
    assign err       = err_r;

    // Payload buffer write port; contents are not reset.
    always_ff @(posedge clock) begin
        if ((state_r == ST_FILL) && xfer_s) begin
            buf_mem[wr_ptr_r] <= pl_data;
        end
    end

    // Control FSM with registered router-side and handshake outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            addr_r      <= 2'd0;
            len_r       <= 6'd0;
            wr_ptr_r    <= 6'd0;
            rd_ptr_r    <= 6'd0;
            parity_r    <= 8'd0;
            pkt_valid_r <= 1'b0;
            data_out_r  <= 8'd0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            cmd_ready_r <= 1'b1;
            pl_ready_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (req_legal_s) begin
                            addr_r      <= tx_addr;
                            len_r       <= tx_len;
                            wr_ptr_r    <= 6'd0;
                            rd_ptr_r    <= 6'd0;
                            parity_r    <= 8'd0;
                            cmd_ready_r <= 1'b0;
                            pl_ready_r  <= 1'b1;
                            state_r     <= ST_FILL;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (xfer_s) begin
                        wr_ptr_r <= wr_ptr_r + 6'd1;
                        // Last payload byte: fold in the header and present it next cycle.
                        if (wr_ptr_r == (len_r - 6'd1)) begin
                            parity_r    <= parity_step(parity_step(parity_r, pl_data), header_s);
                            pl_ready_r  <= 1'b0;
                            pkt_valid_r <= 1'b1;
                            data_out_r  <= header_s;
                            state_r     <= ST_HEADER;
                        end else begin
                            parity_r <= parity_step(parity_r, pl_data);
                        end
                    end
                end
                ST_HEADER: begin
                    if (!busy) begin
                        data_out_r <= buf_mem[0];
                        rd_ptr_r   <= 6'd1;
                        state_r    <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (!busy) begin
                        if (rd_ptr_r == len_r) begin
                            pkt_valid_r <= 1'b0;
                            data_out_r  <= parity_r;
                            state_r     <= ST_PARITY;
                        end else begin
                            data_out_r <= buf_mem[rd_ptr_r];
                            rd_ptr_r   <= rd_ptr_r + 6'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        data_out_r <= 8'd0;
                        done_r     <= 1'b1;
                        state_r    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cmd_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    pkt_valid_r <= 1'b0;
                    data_out_r  <= 8'd0;
                    pl_ready_r  <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
